// File: rtl/udm_initiator.sv
// udm_initiator: bus-request to UDM UART frame initiator with read-reply parser.
// Optional read-response timeout enabled by defining UDM_INITIATOR_TIMEOUT_EN.
module udm_initiator #(
    parameter int CLK_DIV        = 868,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk_i,
    input  logic        arst_n_i,
    input  logic        rx_i,
    output logic        tx_o,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic        resp_o,
    output logic [31:0] rdata_o,
    output logic        busy_o,
    output logic        err_o
);
    localparam int CW = $clog2(CLK_DIV);

    if (CLK_DIV < 4 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("udm_initiator: CLK_DIV must be >= 4 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [3:0] {
        IDLE, TX_SYNC, TX_CMD, TX_ADDR, TX_LEN, TX_DATA, TX_END, RX_DATA, DONE
    } state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic        esc;
    logic        rx_esc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rx_word;

    logic [8:0]    tx_sh;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_left;
    logic          tx_act;
    logic          tx_done;
    logic          tx_rdy;
    logic          tx_load;
    logic [7:0]    tx_byte;
    logic [7:0]    pay;
    logic          need_esc;

    logic [2:0]    rx_s;
    logic          rx_act;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_sh;
    logic          rx_vld;

`ifdef UDM_INITIATOR_TIMEOUT_EN
    logic [31:0] tmo;
`else
    assign err_o = 1'b0;
`endif

    assign ack_o   = (state == IDLE) && req_i;
    assign tx_done = tx_act && (tx_cnt == '0) && (tx_left == 4'd0);
    assign tx_rdy  = !tx_act || tx_done;

    // Pick the next byte to transmit; payload bytes 0x55/0x5A get a 0x5A prefix first
    always_comb begin
        pay      = (state == TX_ADDR) ? addr[{cnt, 3'b000} +: 8] :
                   (state == TX_LEN)  ? ((cnt == 2'd0) ? 8'h04 : 8'h00) :
                                        wdata[{cnt, 3'b000} +: 8];
        need_esc = (state inside {TX_ADDR, TX_LEN, TX_DATA}) && (pay == 8'h55 || pay == 8'h5A) && !esc;
        tx_byte  = (state == TX_SYNC) ? 8'h55 :
                   (state == TX_CMD)  ? (we ? 8'h81 : 8'h82) :
                   need_esc           ? 8'h5A : pay;
        tx_load  = (state inside {TX_SYNC, TX_CMD, TX_ADDR, TX_LEN, TX_DATA}) && tx_rdy;
    end

    // 8N1 transmitter; a load in the final stop cycle chains the next byte with no gap
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            tx_o    <= 1'b1;
            tx_sh   <= '1;
            tx_cnt  <= '0;
            tx_left <= 4'd0;
            tx_act  <= 1'b0;
        end else if (tx_load) begin
            tx_o    <= 1'b0;
            tx_sh   <= {1'b1, tx_byte};
            tx_cnt  <= CW'(CLK_DIV - 1);
            tx_left <= 4'd9;
            tx_act  <= 1'b1;
        end else if (tx_act) begin
            if (tx_cnt != '0) begin
                tx_cnt <= tx_cnt - 1'b1;
            end else if (tx_left == 4'd0) begin
                tx_act <= 1'b0;
            end else begin
                tx_o    <= tx_sh[0];
                tx_sh   <= {1'b1, tx_sh[8:1]};
                tx_left <= tx_left - 4'd1;
                tx_cnt  <= CW'(CLK_DIV - 1);
            end
        end
    end

    // Synchronize rx, detect start on falling edge, sample mid-bit, drop framing errors
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rx_s   <= 3'b111;
            rx_act <= 1'b0;
            rx_cnt <= '0;
            rx_bit <= 4'd0;
            rx_sh  <= 8'h00;
            rx_vld <= 1'b0;
        end else begin
            rx_s   <= {rx_s[1:0], rx_i};
            rx_vld <= 1'b0;
            if (!rx_act) begin
                if (rx_s[2] && !rx_s[1]) begin
                    rx_act <= 1'b1;
                    rx_cnt <= CW'(CLK_DIV / 2 - 1);
                    rx_bit <= 4'd0;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - 1'b1;
            end else begin
                rx_cnt <= CW'(CLK_DIV - 1);
                rx_bit <= rx_bit + 4'd1;
                if (rx_bit == 4'd0) begin
                    if (rx_s[1])
                        rx_act <= 1'b0;
                end else if (rx_bit == 4'd9) begin
                    rx_act <= 1'b0;
                    rx_vld <= rx_s[1];
                end else begin
                    rx_sh <= {rx_s[1], rx_sh[7:1]};
                end
            end
        end
    end

    // Transaction sequencer: frame emission, escape insertion, reply unescaping and completion
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            esc     <= 1'b0;
            rx_esc  <= 1'b0;
            we      <= 1'b0;
            addr    <= 32'h0;
            wdata   <= 32'h0;
            rx_word <= 32'h0;
            rdata_o <= 32'h0;
            resp_o  <= 1'b0;
            busy_o  <= 1'b0;
`ifdef UDM_INITIATOR_TIMEOUT_EN
            tmo     <= 32'h0;
            err_o   <= 1'b0;
`endif
        end else begin
            resp_o <= 1'b0;
            if (rx_vld && state != RX_DATA)
                rx_esc <= 1'b0;
            case (state)
                IDLE: if (req_i) begin
                    we     <= we_i;
                    addr   <= addr_i;
                    wdata  <= wdata_i;
                    busy_o <= 1'b1;
                    rx_esc <= 1'b0;
                    esc    <= 1'b0;
                    cnt    <= 2'd0;
`ifdef UDM_INITIATOR_TIMEOUT_EN
                    err_o  <= 1'b0;
`endif
                    state  <= TX_SYNC;
                end
                TX_SYNC: if (tx_rdy) state <= TX_CMD;
                TX_CMD:  if (tx_rdy) state <= TX_ADDR;
                TX_ADDR, TX_LEN, TX_DATA: if (tx_rdy) begin
                    if (need_esc) begin
                        esc <= 1'b1;
                    end else begin
                        esc <= 1'b0;
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3)
                            state <= (state == TX_ADDR) ? TX_LEN : (state == TX_LEN && we) ? TX_DATA : TX_END;
                    end
                end
                TX_END: if (tx_done) begin
                    if (we) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        state  <= RX_DATA;
`ifdef UDM_INITIATOR_TIMEOUT_EN
                        tmo    <= 32'h0;
`endif
                    end
                end
                RX_DATA: begin
`ifdef UDM_INITIATOR_TIMEOUT_EN
                    tmo <= rx_vld ? 32'h0 : tmo + 32'h1;
                    if (!rx_vld && tmo == 32'(TIMEOUT_CYCLES - 1)) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        err_o  <= 1'b1;
                    end
`endif
                    if (rx_vld) begin
                        if (!rx_esc && rx_sh == 8'h5A) begin
                            rx_esc <= 1'b1;
                        end else begin
                            rx_esc  <= 1'b0;
                            rx_word <= {rx_sh, rx_word[31:8]};
                            cnt     <= cnt + 2'd1;
                            if (cnt == 2'd3)
                                state <= DONE;
                        end
                    end
                end
                DONE: begin
                    rdata_o <= rx_word;
                    resp_o  <= 1'b1;
                    busy_o  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
